// File: rtl/fm_audio_pkg.sv
// Shared constants for the FM audio sample-rate decimator.
package fm_audio_pkg;
  localparam int DEC_RATIO   = 10;
  localparam int SCALE_MUL   = 41;
  localparam int SCALE_SHIFT = 12;
  localparam int PHASE_W     = 4;
endpackage

// File: rtl/fm_boxcar_stage.sv
// Boxcar decimate-by-DEC_RATIO stage: sums DEC_RATIO enabled samples and
// emits the sum with a one-cycle valid pulse.
module fm_boxcar_stage
  import fm_audio_pkg::*;
#(
  parameter int W_IN  = 16,
  parameter int W_OUT = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic signed [W_IN-1:0]   in,
  output logic signed [W_OUT-1:0]  out,
  output logic                     out_valid,
  output logic [PHASE_W-1:0]       phase
);

  logic signed [W_OUT-1:0] acc;

  // Accumulate enabled samples; on the last phase dump the sum and restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      phase     <= '0;
    end else begin
      out_valid <= 1'b0;
      if (ce) begin
        if (phase == PHASE_W'(DEC_RATIO - 1)) begin
          out       <= acc + W_OUT'(in);
          acc       <= '0;
          phase     <= '0;
          out_valid <= 1'b1;
        end else begin
          acc   <= acc + W_OUT'(in);
          phase <= phase + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fm_decimator.sv
// Two-stage boxcar decimator (3.58 MHz -> 358 kHz -> 35.8 kHz) with
// fixed-point rescale back to input amplitude and saturation.
module fm_decimator
  import fm_audio_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int MID_W = IN_W + 4
) (
  input  logic                     ex_clk_3m6,
  input  logic                     reset,
  input  logic signed [IN_W-1:0]   in_sample,
  output logic signed [MID_W-1:0]  mid_sample,
  output logic                     mid_valid,
  output logic                     clk_360k,
  output logic signed [IN_W-1:0]   out_sample,
  output logic                     out_valid,
  output logic                     clk_36k,
  output logic [PHASE_W-1:0]       clk_360k_counter,
  output logic [PHASE_W-1:0]       clk_36k_counter
);

  localparam int SUM_W  = IN_W + 7;
  localparam int PROD_W = IN_W + 13;

  logic signed [SUM_W-1:0]  sum2_p0;
  logic                     vld_p0;
  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1;

  // Multiply by the gain numerator; sized so 100 full-scale samples fit.
  function automatic logic signed [PROD_W-1:0] scale_mul(input logic signed [SUM_W-1:0] s);
    return PROD_W'(s) * PROD_W'(SCALE_MUL);
  endfunction

  // Floor-shift by the gain denominator, then clamp to the input range.
  function automatic logic signed [IN_W-1:0] sat_shift(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] t;
    logic signed [PROD_W-1:0] hi;
    logic signed [PROD_W-1:0] lo;
    t  = p >>> SCALE_SHIFT;
    hi = PROD_W'((1 <<< (IN_W - 1)) - 1);
    lo = ~hi;
    if (t > hi)      return hi[IN_W-1:0];
    else if (t < lo) return lo[IN_W-1:0];
    else             return t[IN_W-1:0];
  endfunction

  fm_boxcar_stage #(.W_IN(IN_W), .W_OUT(MID_W)) u_stage1 (
    .clk       (ex_clk_3m6),
    .reset     (reset),
    .ce        (1'b1),
    .in        (in_sample),
    .out       (mid_sample),
    .out_valid (mid_valid),
    .phase     (clk_360k_counter)
  );

  fm_boxcar_stage #(.W_IN(MID_W), .W_OUT(SUM_W)) u_stage2 (
    .clk       (ex_clk_3m6),
    .reset     (reset),
    .ce        (mid_valid),
    .in        (mid_sample),
    .out       (sum2_p0),
    .out_valid (vld_p0),
    .phase     (clk_36k_counter)
  );

  // Scale pipeline: p0 -> p1 multiply, p1 -> output shift and saturate.
  always_ff @(posedge ex_clk_3m6) begin
    if (reset) begin
      prod_p1    <= '0;
      vld_p1     <= 1'b0;
      out_sample <= '0;
      out_valid  <= 1'b0;
    end else begin
      vld_p1    <= vld_p0;
      if (vld_p0) prod_p1 <= scale_mul(sum2_p0);
      out_valid <= vld_p1;
      if (vld_p1) out_sample <= sat_shift(prod_p1);
    end
  end

  assign clk_360k = mid_valid;
  assign clk_36k  = out_valid;

endmodule

// File: tb/tb_fm_decimator.sv
// Directed testbench for fm_decimator.
module tb_fm_decimator;
  localparam int IN_W  = 16;
  localparam int MID_W = IN_W + 4;

  logic                    ex_clk_3m6 = 1'b0;
  logic                    reset = 1'b1;
  logic signed [IN_W-1:0]  in_sample = '0;
  logic signed [MID_W-1:0] mid_sample;
  logic                    mid_valid;
  logic                    clk_360k;
  logic signed [IN_W-1:0]  out_sample;
  logic                    out_valid;
  logic                    clk_36k;
  logic [3:0]              clk_360k_counter;
  logic [3:0]              clk_36k_counter;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  bit ramp_on = 1'b0;

  fm_decimator #(.IN_W(IN_W), .MID_W(MID_W)) dut (
    .ex_clk_3m6       (ex_clk_3m6),
    .reset            (reset),
    .in_sample        (in_sample),
    .mid_sample       (mid_sample),
    .mid_valid        (mid_valid),
    .clk_360k         (clk_360k),
    .out_sample       (out_sample),
    .out_valid        (out_valid),
    .clk_36k          (clk_36k),
    .clk_360k_counter (clk_360k_counter),
    .clk_36k_counter  (clk_36k_counter)
  );

  always #5 ex_clk_3m6 = ~ex_clk_3m6;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are read and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge ex_clk_3m6);
    #1;
    edge_n++;
    if (ramp_on) in_sample = IN_W'(edge_n);
  endtask

  task automatic restart(input int value);
    ramp_on   = 1'b0;
    reset     = 1'b1;
    in_sample = IN_W'(value);
    tick();
    tick();
    reset  = 1'b0;
    edge_n = 0;
  endtask

  task automatic wait_out(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_mid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (mid_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    bit early;
    bit strobe_err;
    bit cnt_err;
    int last_mid;
    int last_out;
    int n_mid;
    int n_out;

    // Reset state
    restart(0);
    chk("rst_mid_sample", int'(mid_sample), 0);
    chk("rst_mid_valid", int'(mid_valid), 0);
    chk("rst_out_sample", int'(out_sample), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_clk_360k", int'(clk_360k), 0);
    chk("rst_clk_36k", int'(clk_36k), 0);
    chk("rst_c1", int'(clk_360k_counter), 0);
    chk("rst_c2", int'(clk_36k_counter), 0);

    // Constant +1000
    restart(1000);
    early = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (mid_valid) early = 1'b1;
    end
    chk("pos_no_early_mid", int'(early), 0);
    tick();
    chk("pos_mid_valid_e10", int'(mid_valid), 1);
    chk("pos_clk360k_e10", int'(clk_360k), 1);
    chk("pos_mid_sample", int'(mid_sample), 10000);
    chk("pos_c1_e10", int'(clk_360k_counter), 0);
    chk("pos_c2_e10", int'(clk_36k_counter), 0);
    tick();
    chk("pos_mid_valid_drop", int'(mid_valid), 0);
    chk("pos_mid_hold", int'(mid_sample), 10000);
    chk("pos_c2_e11", int'(clk_36k_counter), 1);
    wait_out(200, ok);
    chk("pos_out_timeout", int'(ok), 1);
    chk("pos_out_edge", edge_n, 103);
    chk("pos_out_sample", int'(out_sample), 1000);
    chk("pos_clk36k", int'(clk_36k), 1);
    tick();
    chk("pos_out_valid_drop", int'(out_valid), 0);
    chk("pos_out_hold", int'(out_sample), 1000);

    // Constant -1000: floor rounding toward -inf
    restart(-1000);
    wait_out(200, ok);
    chk("neg_out_timeout", int'(ok), 1);
    chk("neg_out_edge", edge_n, 103);
    chk("neg_out_sample", int'(out_sample), -1001);
    chk("neg_mid_sample", int'(mid_sample), -10000);

    // Positive full scale saturates
    restart(32767);
    wait_out(200, ok);
    chk("satp_out_timeout", int'(ok), 1);
    chk("satp_mid_sample", int'(mid_sample), 327670);
    chk("satp_out_sample", int'(out_sample), 32767);

    // Negative full scale saturates
    restart(-32768);
    wait_out(200, ok);
    chk("satn_out_timeout", int'(ok), 1);
    chk("satn_mid_sample", int'(mid_sample), -327680);
    chk("satn_out_sample", int'(out_sample), -32768);

    // Ramp 0,1,2,...
    restart(0);
    ramp_on = 1'b1;
    wait_mid(20, ok);
    chk("ramp_mid1_timeout", int'(ok), 1);
    chk("ramp_mid1_edge", edge_n, 10);
    chk("ramp_mid1", int'(mid_sample), 45);
    wait_mid(20, ok);
    chk("ramp_mid2_timeout", int'(ok), 1);
    chk("ramp_mid2_edge", edge_n, 20);
    chk("ramp_mid2", int'(mid_sample), 145);
    wait_out(200, ok);
    chk("ramp_out_timeout", int'(ok), 1);
    chk("ramp_out_edge", edge_n, 103);
    chk("ramp_out_sample", int'(out_sample), 49);
    ramp_on = 1'b0;

    // Reset in the middle of a frame at c1=5, c2=4
    restart(1000);
    for (int i = 0; i < 45; i++) tick();
    chk("mid_rst_c1_before", int'(clk_360k_counter), 5);
    chk("mid_rst_c2_before", int'(clk_36k_counter), 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    edge_n = 0;
    chk("mid_rst_c1_after", int'(clk_360k_counter), 0);
    chk("mid_rst_c2_after", int'(clk_36k_counter), 0);
    chk("mid_rst_mid_valid", int'(mid_valid), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_mid_sample", int'(mid_sample), 0);
    early = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (mid_valid || out_valid) early = 1'b1;
    end
    chk("mid_rst_no_pulse", int'(early), 0);
    tick();
    chk("mid_rst_mid_valid_e10", int'(mid_valid), 1);
    chk("mid_rst_mid_sample_e10", int'(mid_sample), 10000);

    // Continuous run: pulse periods and counter bounds
    restart(123);
    last_mid   = -1;
    last_out   = -1;
    n_mid      = 0;
    n_out      = 0;
    strobe_err = 1'b0;
    cnt_err    = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (clk_360k !== mid_valid || clk_36k !== out_valid) strobe_err = 1'b1;
      if (clk_360k_counter > 4'd9 || clk_36k_counter > 4'd9) cnt_err = 1'b1;
      if (mid_valid) begin
        if (last_mid < 0) chk("run_first_mid_edge", edge_n, 10);
        else              chk("run_mid_period", edge_n - last_mid, 10);
        last_mid = edge_n;
        n_mid++;
      end
      if (out_valid) begin
        if (last_out < 0) chk("run_first_out_edge", edge_n, 103);
        else              chk("run_out_period", edge_n - last_out, 100);
        last_out = edge_n;
        n_out++;
      end
    end
    chk("run_mid_count", n_mid, 100);
    chk("run_out_count", n_out, 9);
    chk("run_strobe_match", int'(strobe_err), 0);
    chk("run_counter_bound", int'(cnt_err), 0);
    chk("run_out_sample", int'(out_sample), 123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
